// File: rtl/sram_stage_sequencer_if.sv
// Port bundle between the SRAM sequencer and the UART receiver,
// the processing-stage chain, the VGA reader and the SRAM controller.
interface sram_stage_sequencer_if #(
    parameter int NUM_STAGES = 3,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16
);
    logic                         start_i;
    logic [ADDR_W-1:0]            uart_addr_i;
    logic [DATA_W-1:0]            uart_wdata_i;
    logic                         uart_we_n_i;
    logic                         uart_init_o;
    logic                         uart_enable_o;
    logic [NUM_STAGES*ADDR_W-1:0] stage_addr_i;
    logic [NUM_STAGES*DATA_W-1:0] stage_wdata_i;
    logic [NUM_STAGES-1:0]        stage_we_n_i;
    logic [NUM_STAGES-1:0]        stage_enable_o;
    logic [NUM_STAGES-1:0]        stage_done_i;
    logic [ADDR_W-1:0]            vga_addr_i;
    logic                         vga_enable_o;
    logic [ADDR_W-1:0]            sram_addr_o;
    logic [DATA_W-1:0]            sram_wdata_o;
    logic                         sram_we_n_o;
    logic [2:0]                   state_o;
    logic [1:0]                   stage_idx_o;
    logic                         seq_done_o;
    logic                         timeout_err_o;

    modport slave (
        input  start_i, uart_addr_i, uart_wdata_i, uart_we_n_i,
        input  stage_addr_i, stage_wdata_i, stage_we_n_i, stage_done_i,
        input  vga_addr_i,
        output uart_init_o, uart_enable_o, stage_enable_o, vga_enable_o,
        output sram_addr_o, sram_wdata_o, sram_we_n_o,
        output state_o, stage_idx_o, seq_done_o, timeout_err_o
    );

    modport master (
        output start_i, uart_addr_i, uart_wdata_i, uart_we_n_i,
        output stage_addr_i, stage_wdata_i, stage_we_n_i, stage_done_i,
        output vga_addr_i,
        input  uart_init_o, uart_enable_o, stage_enable_o, vga_enable_o,
        input  sram_addr_o, sram_wdata_o, sram_we_n_o,
        input  state_o, stage_idx_o, seq_done_o, timeout_err_o
    );
endinterface

// File: rtl/sram_stage_sequencer.sv
// SRAM port owner for the image decompressor: UART load, then the
// processing-stage chain, then back to the VGA reader.
module sram_stage_sequencer #(
    parameter int                    NUM_STAGES    = 3,
    parameter int                    ADDR_W        = 18,
    parameter int                    DATA_W        = 16,
    parameter int                    UART_TIMEOUT  = 50000000,
    parameter int                    STAGE_TIMEOUT = 0,
    parameter logic [NUM_STAGES-1:0] SKIP_MASK     = '0
) (
    input logic                   CLOCK_50_I,
    input logic                   resetn,
    sram_stage_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_UART_EN   = 3'd1;
    localparam logic [2:0] S_UART_WAIT = 3'd2;
    localparam logic [2:0] S_STAGE_EN  = 3'd3;
    localparam logic [2:0] S_STAGE_RUN = 3'd4;

    localparam logic [25:0] UART_LIM = 26'(UART_TIMEOUT - 1);
    localparam logic [31:0] WD_LIM   = 32'(STAGE_TIMEOUT - 1);
    localparam bit          WD_ON    = (STAGE_TIMEOUT != 0);

    logic [2:0]            state;
    logic [1:0]            idx;
    logic [25:0]           uart_timer;
    logic [31:0]           wd_cnt;
    logic                  uart_init_q;
    logic                  uart_enable_q;
    logic                  vga_enable_q;
    logic                  seq_done_q;
    logic                  timeout_err_q;
    logic [NUM_STAGES-1:0] stage_en_q;

    logic [NUM_STAGES-1:0] idx_onehot;
    logic [1:0]            first_idx;
    logic [1:0]            next_idx;
    logic                  has_first;
    logic                  has_next;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic                  sel_we_n;
    logic                  done_hit;
    logic                  uart_exit;
    logic                  wd_expire;

    // Descending scan so the lowest qualifying stage wins.
    always_comb begin
        idx_onehot = '0;
        first_idx  = '0;
        next_idx   = '0;
        has_first  = 1'b0;
        has_next   = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_we_n   = 1'b1;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (!SKIP_MASK[i]) begin
                first_idx = 2'(i);
                has_first = 1'b1;
                if (i > int'(idx)) begin
                    next_idx = 2'(i);
                    has_next = 1'b1;
                end
            end
            if (idx == 2'(i)) begin
                idx_onehot[i] = 1'b1;
                sel_addr      = bus.stage_addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata     = bus.stage_wdata_i[i*DATA_W +: DATA_W];
                sel_we_n      = bus.stage_we_n_i[i];
            end
        end
    end

    assign done_hit  = |(bus.stage_done_i & idx_onehot);
    assign uart_exit = (uart_timer == UART_LIM) &&
                       (bus.uart_addr_i != '0) && bus.uart_we_n_i;
    assign wd_expire = WD_ON && (wd_cnt == WD_LIM);

    // Idle timer runs in every state; any UART write restarts it.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            uart_timer <= '0;
        end else if (uart_init_q || !bus.uart_we_n_i) begin
            uart_timer <= '0;
        end else begin
            uart_timer <= uart_timer + 26'd1;
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            idx           <= '0;
            wd_cnt        <= '0;
            uart_init_q   <= 1'b0;
            uart_enable_q <= 1'b0;
            vga_enable_q  <= 1'b1;
            seq_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            stage_en_q    <= '0;
        end else begin
            uart_init_q   <= 1'b0;
            uart_enable_q <= 1'b0;
            seq_done_q    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        uart_init_q  <= 1'b1;
                        vga_enable_q <= 1'b0;
                        state        <= S_UART_EN;
                    end
                end
                S_UART_EN: begin
                    uart_enable_q <= 1'b1;
                    state         <= S_UART_WAIT;
                end
                S_UART_WAIT: begin
                    if (uart_exit) begin
                        uart_init_q  <= 1'b1;
                        vga_enable_q <= 1'b1;
                        if (has_first) begin
                            idx   <= first_idx;
                            state <= S_STAGE_EN;
                        end else begin
                            seq_done_q <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                end
                S_STAGE_EN: begin
                    stage_en_q <= idx_onehot;
                    wd_cnt     <= '0;
                    state      <= S_STAGE_RUN;
                end
                S_STAGE_RUN: begin
                    if (done_hit) begin
                        stage_en_q <= '0;
                        if (has_next) begin
                            idx   <= next_idx;
                            state <= S_STAGE_EN;
                        end else begin
                            seq_done_q <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end else if (wd_expire) begin
                        timeout_err_q <= 1'b1;
                        stage_en_q    <= '0;
                        state         <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.sram_addr_o  = bus.vga_addr_i;
        bus.sram_wdata_o = bus.uart_wdata_i;
        bus.sram_we_n_o  = 1'b1;
        if (state == S_UART_EN || state == S_UART_WAIT) begin
            bus.sram_addr_o  = bus.uart_addr_i;
            bus.sram_wdata_o = bus.uart_wdata_i;
            bus.sram_we_n_o  = bus.uart_we_n_i;
        end else if (state == S_STAGE_RUN) begin
            bus.sram_addr_o  = sel_addr;
            bus.sram_wdata_o = sel_wdata;
            bus.sram_we_n_o  = sel_we_n;
        end
    end

    assign bus.uart_init_o    = uart_init_q;
    assign bus.uart_enable_o  = uart_enable_q;
    assign bus.stage_enable_o = stage_en_q;
    assign bus.vga_enable_o   = vga_enable_q;
    assign bus.state_o        = state;
    assign bus.stage_idx_o    = idx;
    assign bus.seq_done_o     = seq_done_q;
    assign bus.timeout_err_o  = timeout_err_q;
endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Bench for sram_stage_sequencer: one DUT with watchdog, one with a
// skipped middle stage, sharing stimulus; outputs picked by sel.
module tb_sram_stage_sequencer;
    localparam int NS = 3;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int UT = 16;
    localparam int ST = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sram_stage_sequencer_if #(.NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW)) ifa ();
    sram_stage_sequencer_if #(.NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW)) ifb ();

    sram_stage_sequencer #(
        .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .UART_TIMEOUT(UT),
        .STAGE_TIMEOUT(ST), .SKIP_MASK(3'b000)
    ) dut_a (.CLOCK_50_I(clk), .resetn(resetn), .bus(ifa));

    sram_stage_sequencer #(
        .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .UART_TIMEOUT(UT),
        .STAGE_TIMEOUT(0), .SKIP_MASK(3'b010)
    ) dut_b (.CLOCK_50_I(clk), .resetn(resetn), .bus(ifb));

    logic             start;
    logic [AW-1:0]    uaddr;
    logic [DW-1:0]    uwdata;
    logic             uwe_n;
    logic [NS*AW-1:0] saddr;
    logic [NS*DW-1:0] swdata;
    logic [NS-1:0]    swe_n;
    logic [NS-1:0]    sdone;
    logic [AW-1:0]    vaddr;

    assign ifa.start_i = start;       assign ifb.start_i = start;
    assign ifa.uart_addr_i = uaddr;   assign ifb.uart_addr_i = uaddr;
    assign ifa.uart_wdata_i = uwdata; assign ifb.uart_wdata_i = uwdata;
    assign ifa.uart_we_n_i = uwe_n;   assign ifb.uart_we_n_i = uwe_n;
    assign ifa.stage_addr_i = saddr;  assign ifb.stage_addr_i = saddr;
    assign ifa.stage_wdata_i = swdata; assign ifb.stage_wdata_i = swdata;
    assign ifa.stage_we_n_i = swe_n;  assign ifb.stage_we_n_i = swe_n;
    assign ifa.stage_done_i = sdone;  assign ifb.stage_done_i = sdone;
    assign ifa.vga_addr_i = vaddr;    assign ifb.vga_addr_i = vaddr;

    logic          sel = 1'b0;
    logic [2:0]    o_state;
    logic [1:0]    o_idx;
    logic          o_uinit, o_uen, o_vga, o_sdn, o_err, o_we_n;
    logic [NS-1:0] o_sen;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;

    assign o_state = sel ? ifb.state_o        : ifa.state_o;
    assign o_idx   = sel ? ifb.stage_idx_o    : ifa.stage_idx_o;
    assign o_uinit = sel ? ifb.uart_init_o    : ifa.uart_init_o;
    assign o_uen   = sel ? ifb.uart_enable_o  : ifa.uart_enable_o;
    assign o_vga   = sel ? ifb.vga_enable_o   : ifa.vga_enable_o;
    assign o_sdn   = sel ? ifb.seq_done_o     : ifa.seq_done_o;
    assign o_err   = sel ? ifb.timeout_err_o  : ifa.timeout_err_o;
    assign o_sen   = sel ? ifb.stage_enable_o : ifa.stage_enable_o;
    assign o_addr  = sel ? ifb.sram_addr_o    : ifa.sram_addr_o;
    assign o_wdata = sel ? ifb.sram_wdata_o   : ifa.sram_wdata_o;
    assign o_we_n  = sel ? ifb.sram_we_n_o    : ifa.sram_we_n_o;

    // Sticky flag: the skipped stage of dut_b must never be enabled or selected.
    logic b_bad = 1'b0;
    always @(posedge clk)
        if (ifb.stage_enable_o[1] || (ifb.state_o == 3'd4 && ifb.stage_idx_o == 2'd1))
            b_bad <= 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start  = 1'b0;
        uaddr  = '0;
        uwdata = '0;
        uwe_n  = 1'b1;
        saddr  = '0;
        swdata = '0;
        swe_n  = '1;
        sdone  = '0;
        vaddr  = AW'($urandom);
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic uart_load(input int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < n; k++) begin
            uaddr  = AW'($urandom_range(1, 2**AW - 1));
            uwdata = DW'($urandom);
            uwe_n  = 1'b0;
            tick();
        end
        uwe_n = 1'b1;
    endtask

    task automatic wait_exit(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (o_uinit !== 1'b1 && cyc < 200);
        if (o_uinit !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        n_tests++;
        if (o_state !== 3'd0 || o_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d idx=%0d, required 0/0", o_state, o_idx);
        end
        n_tests++;
        if (o_vga !== 1'b1 || o_uinit !== 1'b0 || o_uen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_uart_vga: vga=%b init=%b en=%b, required 1/0/0", o_vga, o_uinit, o_uen);
        end
        n_tests++;
        if (o_sen !== '0 || o_sdn !== 1'b0 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: sen=%b done=%b err=%b, required 000/0/0", o_sen, o_sdn, o_err);
        end
        n_tests++;
        if (o_we_n !== 1'b1 || o_addr !== vaddr) begin
            n_fail++;
            $display("FAIL reset_mux: we_n=%b addr=%h, required 1/%h", o_we_n, o_addr, vaddr);
        end
    endtask

    // Reference: stages are visited in ascending order of the unskipped bits.
    task automatic seq_scenario(input logic [NS-1:0] mask, input int rounds);
        int            order[$];
        int            n, cyc, d, s, other;
        logic [NS-1:0] exp_en;
        logic [AW-1:0] a;
        for (int i = 0; i < NS; i++) if (!mask[i]) order.push_back(i);
        for (int r = 0; r < rounds; r++) begin
            do_reset();
            start = 1'b1;
            tick();
            start = 1'b0;
            n_tests++;
            if (o_uinit !== 1'b1 || o_state !== 3'd1 || o_vga !== 1'b0) begin
                n_fail++;
                $display("FAIL start_pulse: init=%b state=%0d vga=%b, required 1/1/0", o_uinit, o_state, o_vga);
            end
            tick();
            n_tests++;
            if (o_uen !== 1'b1 || o_uinit !== 1'b0 || o_state !== 3'd2) begin
                n_fail++;
                $display("FAIL uart_enable: en=%b init=%b state=%0d, required 1/0/2", o_uen, o_uinit, o_state);
            end
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                uaddr  = AW'(k + 1);
                uwdata = DW'($urandom);
                uwe_n  = 1'b0;
                #1;
                if (k == 0) begin
                    n_tests++;
                    if (o_addr !== uaddr || o_wdata !== uwdata || o_we_n !== 1'b0) begin
                        n_fail++;
                        $display("FAIL uart_mux: addr=%h data=%h we_n=%b, required %h/%h/0", o_addr, o_wdata, o_we_n, uaddr, uwdata);
                    end
                end
                tick();
            end
            uwe_n = 1'b1;
            wait_exit(cyc);
            n_tests++;
            if (cyc !== UT || o_state !== 3'd3 || o_vga !== 1'b1) begin
                n_fail++;
                $display("FAIL uart_exit: cycles=%0d state=%0d vga=%b, required %0d/3/1", cyc, o_state, o_vga, UT);
            end
            foreach (order[j]) begin
                s = order[j];
                exp_en = '0;
                exp_en[s] = 1'b1;
                tick();
                n_tests++;
                if (o_sen !== exp_en || o_state !== 3'd4 || o_idx !== 2'(s)) begin
                    n_fail++;
                    $display("FAIL stage_enable: sen=%b state=%0d idx=%0d, required %b/4/%0d", o_sen, o_state, o_idx, exp_en, s);
                end
                a = AW'($urandom);
                saddr[s*AW +: AW] = a;
                swe_n[s] = 1'b0;
                #1;
                n_tests++;
                if (o_addr !== a || o_we_n !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stage_mux: addr=%h we_n=%b, required %h/0", o_addr, o_we_n, a);
                end
                other = (s + 1) % NS;
                sdone = '0;
                sdone[other] = 1'b1;
                d = $urandom_range(1, 5);
                repeat (d) tick();
                n_tests++;
                if (o_sen !== exp_en || o_state !== 3'd4) begin
                    n_fail++;
                    $display("FAIL inactive_done: sen=%b state=%0d, required %b/4", o_sen, o_state, exp_en);
                end
                sdone = '0;
                sdone[s] = 1'b1;
                tick();
                sdone = '0;
                swe_n = '1;
                if (j < order.size() - 1) begin
                    n_tests++;
                    if (o_sen !== '0 || o_state !== 3'd3 || o_sdn !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stage_advance: sen=%b state=%0d done=%b, required 000/3/0", o_sen, o_state, o_sdn);
                    end
                end else begin
                    n_tests++;
                    if (o_sen !== '0 || o_state !== 3'd0 || o_sdn !== 1'b1 || o_err !== 1'b0) begin
                        n_fail++;
                        $display("FAIL seq_done: sen=%b state=%0d done=%b err=%b, required 000/0/1/0", o_sen, o_state, o_sdn, o_err);
                    end
                end
            end
            tick();
            n_tests++;
            if (o_sdn !== 1'b0 || o_state !== 3'd0) begin
                n_fail++;
                $display("FAIL seq_done_once: done=%b state=%0d, required 0/0", o_sdn, o_state);
            end
        end
    endtask

    task automatic test_full_sequence();
        sel = 1'b0;
        seq_scenario(3'b000, 3);
    endtask

    task automatic test_skip();
        sel = 1'b1;
        b_bad = 1'b0;
        seq_scenario(3'b010, 2);
        n_tests++;
        if (b_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL skip_stage1: seen=%b, required 0", b_bad);
        end
        sel = 1'b0;
    endtask

    task automatic test_watchdog();
        int cyc, cnt;
        bit sd_seen;
        sel = 1'b0;
        do_reset();
        uart_load(2);
        wait_exit(cyc);
        tick();
        n_tests++;
        if (cyc !== UT || o_sen !== 3'b001 || o_state !== 3'd4) begin
            n_fail++;
            $display("FAIL wd_entry: cycles=%0d sen=%b state=%0d, required %0d/001/4", cyc, o_sen, o_state, UT);
        end
        cnt = 0;
        sd_seen = 1'b0;
        while (o_err !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
            if (o_sdn === 1'b1) sd_seen = 1'b1;
        end
        n_tests++;
        if (cnt !== ST) begin
            n_fail++;
            $display("FAIL wd_latency: cycles=%0d, required %0d", cnt, ST);
        end
        n_tests++;
        if (o_sen !== '0 || o_state !== 3'd0 || sd_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_abort: sen=%b state=%0d done_seen=%b, required 000/0/0", o_sen, o_state, sd_seen);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (o_err !== 1'b1 || o_state !== 3'd1) begin
            n_fail++;
            $display("FAIL wd_sticky: err=%b state=%0d, required 1/1", o_err, o_state);
        end
    endtask

    task automatic test_collision();
        int cyc;
        sel = 1'b0;
        do_reset();
        uart_load(1);
        wait_exit(cyc);
        tick();
        repeat (ST - 1) tick();
        sdone = 3'b001;
        tick();
        sdone = '0;
        n_tests++;
        if (o_err !== 1'b0 || o_state !== 3'd3 || o_sen !== '0) begin
            n_fail++;
            $display("FAIL collide_done_wins: err=%b state=%0d sen=%b, required 0/3/000", o_err, o_state, o_sen);
        end
        tick();
        n_tests++;
        if (o_sen !== 3'b010) begin
            n_fail++;
            $display("FAIL collide_next: sen=%b, required 010", o_sen);
        end
        sdone = 3'b010;
        tick();
        sdone = '0;
        tick();
        sdone = 3'b100;
        tick();
        sdone = '0;
        n_tests++;
        if (o_sdn !== 1'b1 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_finish: done=%b err=%b, required 1/0", o_sdn, o_err);
        end
    endtask

    task automatic test_mux_reset();
        int            cyc;
        logic [DW-1:0] wd;
        sel = 1'b0;
        do_reset();
        uart_load(3);
        wait_exit(cyc);
        tick();
        sdone = 3'b001;
        tick();
        sdone = '0;
        swe_n = '0;
        #1;
        n_tests++;
        if (o_state !== 3'd3 || o_we_n !== 1'b1 || o_addr !== vaddr) begin
            n_fail++;
            $display("FAIL mux_stage_en: state=%0d we_n=%b addr=%h, required 3/1/%h", o_state, o_we_n, o_addr, vaddr);
        end
        swe_n = '1;
        tick();
        sdone = 3'b010;
        tick();
        sdone = '0;
        tick();
        wd = DW'($urandom);
        saddr[2*AW +: AW] = 18'h2ABCD;
        swdata[2*DW +: DW] = wd;
        swe_n = 3'b011;
        vaddr = AW'($urandom);
        #1;
        n_tests++;
        if (o_idx !== 2'd2 || o_addr !== 18'h2ABCD || o_we_n !== 1'b0 || o_wdata !== wd) begin
            n_fail++;
            $display("FAIL mux_stage2: idx=%0d addr=%h we_n=%b data=%h, required 2/2abcd/0/%h", o_idx, o_addr, o_we_n, o_wdata, wd);
        end
        #1;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (o_we_n !== 1'b1 || o_addr !== vaddr || o_sen !== '0 || o_state !== 3'd0) begin
            n_fail++;
            $display("FAIL mux_async_reset: we_n=%b addr=%h sen=%b state=%0d, required 1/%h/000/0", o_we_n, o_addr, o_sen, o_state, vaddr);
        end
        @(negedge clk);
        resetn = 1'b1;
        idle_inputs();
    endtask

    task automatic test_uart_boundary();
        int cyc;
        bit init_seen;
        sel = 1'b0;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        uaddr = '0;
        uwe_n = 1'b0;
        tick();
        uwe_n = 1'b1;
        start = 1'b1;
        init_seen = 1'b0;
        repeat (3 * UT) begin
            tick();
            if (o_uinit === 1'b1) init_seen = 1'b1;
        end
        start = 1'b0;
        n_tests++;
        if (o_state !== 3'd2 || init_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL uart_addr_zero: state=%0d init_seen=%b, required 2/0", o_state, init_seen);
        end
        uaddr = AW'($urandom_range(1, 2**AW - 1));
        uwe_n = 1'b0;
        tick();
        uwe_n = 1'b1;
        repeat (UT - 1) tick();
        uwe_n = 1'b0;
        tick();
        uwe_n = 1'b1;
        n_tests++;
        if (o_uinit !== 1'b0 || o_state !== 3'd2) begin
            n_fail++;
            $display("FAIL write_at_expiry: init=%b state=%0d, required 0/2", o_uinit, o_state);
        end
        wait_exit(cyc);
        n_tests++;
        if (cyc !== UT || o_state !== 3'd3) begin
            n_fail++;
            $display("FAIL exit_after_rewrite: cycles=%0d state=%0d, required %0d/3", cyc, o_state, UT);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_full_sequence();
        test_skip();
        test_watchdog();
        test_collision();
        test_mux_reset();
        test_uart_boundary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
